// File: rtl/mem_sram_responder.sv
// Single-port SRAM responder for a valid/ready memory bus. Define MEM_SRAM_ERR_EN to flag out-of-range and misaligned accesses.
// Latency: mem_ready pulses for one cycle, WAIT_CYCLES cycles after the edge that samples mem_valid.
// Backpressure: none. Requests are accepted only in IDLE, and every RESP is followed by at least one idle edge.
module mem_sram_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic          from_idle;
    logic          go_resp;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_wstrb;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          misaligned;
    logic          acc_err;
    logic          wr_en;
    logic [31:0]   rd_word;
    logic          unused_sink;

    // With no wait states, the access happens on the sampling edge itself, so it uses the live bus.
    assign from_idle  = (state == S_IDLE);
    assign acc_addr   = from_idle ? mem_addr  : addr_q;
    assign acc_wdata  = from_idle ? mem_wdata : wdata_q;
    assign acc_wstrb  = from_idle ? mem_wstrb : wstrb_q;
    assign idx        = acc_addr[AW+1:2];
    assign in_range   = (acc_addr[31:AW+2] == '0);
    assign misaligned = |acc_addr[1:0];
    assign rd_word    = in_range ? mem[idx] : 32'h0;

    always_comb begin
        go_resp = 1'b0;
        if (reset) begin
            if (from_idle && mem_valid && (WAIT_CYCLES == 0))
                go_resp = 1'b1;
            if ((state == S_WAIT) && (cnt == 4'd0))
                go_resp = 1'b1;
        end
    end

`ifdef MEM_SRAM_ERR_EN
    assign acc_err = !in_range || misaligned;
    assign wr_en   = go_resp && in_range && !misaligned && (|acc_wstrb);
`else
    assign acc_err = 1'b0;
    assign wr_en   = go_resp && in_range && (|acc_wstrb);
`endif

    assign unused_sink = &{1'b0, mem_instr, misaligned};

    // The array is not reset; its contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i])
                    mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            mem_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_ready <= 1'b0;
                    mem_rdata <= 32'h0;
                    mem_err   <= 1'b0;
                    if (mem_valid) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        if (WAIT_CYCLES == 0) begin
                            state     <= S_RESP;
                            mem_ready <= 1'b1;
                            mem_rdata <= rd_word;
                            mem_err   <= acc_err;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= S_RESP;
                        mem_ready <= 1'b1;
                        mem_rdata <= rd_word;
                        mem_err   <= acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    mem_ready <= 1'b0;
                    mem_rdata <= 32'h0;
                    mem_err   <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    mem_ready <= 1'b0;
                    mem_rdata <= 32'h0;
                    mem_err   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_sram_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) checked against a word-array reference model.
module tb_mem_sram_responder;
    localparam int DW = 256;
`ifdef MEM_SRAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        v     [2];
    logic        ins   [2];
    logic [31:0] a     [2];
    logic [31:0] wd    [2];
    logic [3:0]  ws    [2];
    logic        rdy0, rdy1, er0, er1;
    logic [31:0] rd0, rd1;

    logic [31:0] mdl [2][DW];
    exp_t q0 [$];
    exp_t q1 [$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_sram_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(rst_n[0]), .mem_valid(v[0]), .mem_instr(ins[0]),
        .mem_addr(a[0]), .mem_wdata(wd[0]), .mem_wstrb(ws[0]),
        .mem_ready(rdy0), .mem_rdata(rd0), .mem_err(er0));

    mem_sram_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(3)) u1 (
        .clk(clk), .reset(rst_n[1]), .mem_valid(v[1]), .mem_instr(ins[1]),
        .mem_addr(a[1]), .mem_wdata(wd[1]), .mem_wstrb(ws[1]),
        .mem_ready(rdy1), .mem_rdata(rd1), .mem_err(er1));

    function automatic int wc(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic get_rdy(input int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference behaviour: a plain word array, with bytes merged under the strobe.
    task automatic model(input int d, input logic [31:0] ad, input logic [31:0] wdt,
                         input logic [3:0] st, output logic [31:0] rdata, output logic err);
        bit in_rng = (ad < 32'(4 * DW));
        bit mis    = (ad % 4) != 0;
        int w      = int'(ad / 4);
        rdata = in_rng ? mdl[d][w] : 32'h0;
        err   = ERR_EN && (!in_rng || mis);
        if (in_rng && st != 4'h0 && !(ERR_EN && mis)) begin
            for (int i = 0; i < 4; i++)
                if (st[i]) mdl[d][w][8*i +: 8] = wdt[8*i +: 8];
        end
    endtask

    task automatic txn(input int d, input logic [31:0] ad, input logic [31:0] wdt,
                       input logic [3:0] st, input bit hold_extra, input bit drop_early,
                       input bit chk);
        exp_t e;
        bit   seen;
        @(negedge clk);
        v[d] = 1'b1; a[d] = ad; wd[d] = wdt; ws[d] = st; ins[d] = 1'($urandom);
        model(d, ad, wdt, st, e.rdata, e.err);
        e.chk = chk;
        e.cyc = cyc + 1 + wc(d);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (get_rdy(d)) begin
                seen = 1'b1;
                break;
            end
            if (drop_early && t == 0) v[d] = 1'b0;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d addr 0x%08h: no mem_ready within 50 cycles", d, ad);
        end
        if (hold_extra) @(negedge clk);
        v[d] = 1'b0;
        a[d] = $urandom; wd[d] = $urandom; ws[d] = 4'($urandom);
    endtask

    task automatic mon(input int d, input logic r, input logic [31:0] data, input logic e);
        exp_t x;
        if (r) begin
            checks++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL spurious_ready dut%0d: mem_ready=1 at cycle %0d with nothing outstanding", d, cyc);
            end else begin
                x = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("latency_dut%0d", d), 32'(cyc), 32'(x.cyc));
                check($sformatf("err_dut%0d", d), {31'h0, e}, {31'h0, x.err});
                if (x.chk) check($sformatf("rdata_dut%0d", d), data, x.rdata);
            end
        end else begin
            check($sformatf("idle_zero_dut%0d", d), {data[31:1], data[0] | e}, 32'h0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, rdy0, rd0, er0);
        mon(1, rdy1, rd1, er1);
    end

    task automatic rand_txn(input int d);
        logic [31:0] ad;
        int r = $urandom_range(0, 11);
        if (r < 6)       ad = {22'h0, 8'($urandom), 2'b00};
        else if (r < 8)  ad = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
        else if (r == 8) ad = 32'h3FC;
        else if (r == 9) ad = 32'h400;
        else             ad = 32'h400 + 32'($urandom_range(0, 32'hBFF));
        txn(d, ad, $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
            1'($urandom), (d == 1) ? 1'($urandom) : 1'b0, 1'b1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; v[d] = 1'b0; ins[d] = 1'b0;
            a[d] = 32'h0; wd[d] = 32'h0; ws[d] = 4'h0;
        end
        #2;
        check("reset_ready", {31'h0, rdy0 | rdy1}, 32'h0);
        check("reset_rdata", rd0 | rd1, 32'h0);
        check("reset_err", {31'h0, er0 | er1}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DW; i++)
                txn(d, 32'(i * 4), $urandom, 4'hF, 1'b0, 1'b0, 1'b0);

        // Full-word write then read back at the top word, then a byte-lane merge.
        txn(0, 32'h3FC, 32'h12345678, 4'hF, 1'b0, 1'b0, 1'b1);
        txn(0, 32'h3FC, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        txn(0, 32'h10, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 1'b1);
        txn(0, 32'h11, 32'h00000011, 4'h1, 1'b0, 1'b0, 1'b1);
        txn(0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        // Wait-state read with valid held through the RESP cycle.
        txn(1, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        txn(1, 32'h4, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of a waited write must drop it.
        @(negedge clk);
        v[1] = 1'b1; a[1] = 32'h20; wd[1] = 32'hDEADBEEF; ws[1] = 4'hF;
        @(posedge clk);
        #2 rst_n[1] = 1'b0; v[1] = 1'b0;
        #1 check("ready_in_reset", {31'h0, rdy1}, 32'h0);
        #1 rst_n[1] = 1'b1;
        repeat (8) @(negedge clk);
        txn(1, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        // Out-of-range and misaligned accesses, followed by a read of the neighbouring word.
        for (int d = 0; d < 2; d++) begin
            txn(d, 32'h400, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
            txn(d, 32'h404, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 1'b1);
            txn(d, 32'h22, 32'h55667788, 4'hF, 1'b0, 1'b0, 1'b1);
            txn(d, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        end

        // Counter loop: the loaded value comes from the model, never from the DUT.
        for (int d = 0; d < 2; d++) begin
            txn(d, 32'h3FC, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1);
            for (int it = 0; it < 10; it++) begin
                txn(d, 32'h3FC, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
                txn(d, 32'h3FC, mdl[d][255] + 32'h1, 4'hF, 1'b0, 1'b0, 1'b1);
            end
            txn(d, 32'h3FC, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
            check($sformatf("loop_final_dut%0d", d), mdl[d][255], 32'h0000000A);
        end

        for (int n = 0; n < 150; n++) begin
            rand_txn(0);
            rand_txn(1);
        end

        repeat (10) @(negedge clk);
        check("drain_q0", 32'(q0.size()), 32'h0);
        check("drain_q1", 32'(q1.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule

// File: doc/mem_sram_responder.md
MEM_SRAM_RESPONDER -- requirements
Module: mem_sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, memory depth in 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, extra wait states per access (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_valid  input  1  request pending from initiator.
REQ-006 SHALL have port mem_instr  input  1  fetch qualifier; no functional effect.
REQ-007 SHALL have port mem_addr  input  32  byte address.
REQ-008 SHALL have port mem_wdata  input  32  write data.
REQ-009 SHALL have port mem_wstrb  input  4  byte-lane write enables; 0 = read.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-012 SHALL have port mem_err  output  1  access fault, valid while mem_ready=1.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT skipped when WAIT_CYCLES=0.
REQ-014 IDLE: on edge sampling mem_valid=1, latch addr/wdata/wstrb; enter RESP if WAIT_CYCLES=0, else WAIT with counter=WAIT_CYCLES-1.
REQ-015 WAIT: decrement counter each edge; enter RESP on edge where counter=0; mem_valid not re-sampled.
REQ-016 Latency: valid sampled at edge k -> mem_ready=1 for exactly the cycle after edge k+WAIT_CYCLES.
REQ-017 Memory access (read capture and byte-lane write) SHALL occur on the edge entering RESP, using latched values.
REQ-018 Word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored for indexing.
REQ-019 Write: update only lanes with mem_wstrb[i]=1 (lane i = bits 8i+7:8i); mem_rdata returns pre-write word.
REQ-020 Out-of-range (addr >= 4*DEPTH_WORDS): no write, mem_rdata=0, transaction still completes with mem_ready.
REQ-021 RESP: next edge returns to IDLE unconditionally; mem_valid sampled in RESP SHALL be ignored (min one idle cycle between transactions).
REQ-022 mem_rdata and mem_err SHALL be 0 whenever mem_ready=0.
REQ-023 Initiator contract: mem_valid/addr/wdata/wstrb held stable until mem_ready; deassertion of mem_valid during WAIT SHALL NOT abort the transaction.

Reset
REQ-024 reset=0 SHALL immediately force state=IDLE, counter=0, mem_ready=0, mem_rdata=0, mem_err=0.
REQ-025 Reset during WAIT SHALL discard the pending transaction; no write committed.
REQ-026 Memory array contents SHALL NOT be reset.

Configuration
REQ-027 Macro MEM_SRAM_ERR_EN defined: mem_err=1 with mem_ready for out-of-range addresses, and for misaligned accesses (addr[1:0]!=0), which additionally SHALL suppress the write.
REQ-028 Macro MEM_SRAM_ERR_EN undefined: mem_err tied 0; misaligned accesses proceed per REQ-018; out-of-range per REQ-020.

Verification
REQ-029 WAIT_CYCLES=0: write addr 0x3FC, wdata 0x12345678, wstrb 0xF, then read 0x3FC -> ready 1 cycle after each sample edge, read rdata=0x12345678.
REQ-030 Byte strobes: word 0x10 = 0xAABBCCDD, write 0x00000011 wstrb 0x1 -> rdata during write=0xAABBCCDD, later read=0xAABBCC11.
REQ-031 WAIT_CYCLES=3: read 0x0 valid at edge k -> ready high only after edge k+3, exactly one cycle; valid held into RESP produces no second ready in that RESP cycle.
REQ-032 Reset pulse (reset=0) during WAIT of write 0xDEADBEEF to 0x20 -> ready stays 0, later read 0x20 returns prior value.
REQ-033 With MEM_SRAM_ERR_EN: read 0x400 (DEPTH_WORDS=256) -> ready=1, err=1, rdata=0; write to 0x22 -> err=1, memory unchanged.
REQ-034 Counter loop (lw/addi/sw to 0x3FC, 10 iterations, back-to-back) -> final word 0x0000000A, no hang.
